// File: rtl/mult_fu.sv
// mult_fu: RV32 M-extension multiply functional unit.
//
// Takes MUL / MULH / MULHSU / MULHU ops from the reservation station, extends
// the operands to 64 bits and feeds a fixed-latency pipelined multiplier.
// Destination tag and function travel alongside in a side pipeline. The
// selected half of the product is queued in an output FIFO toward the CDB.
// Issue is credit-limited by an occupancy counter covering both in-flight and
// buffered ops, so the non-stallable multiplier never produces a result with
// nowhere to go.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-low
//   flush        squash every op in flight and buffered
//   issue_valid  op presented
//   issue_ready  op will be accepted this cycle
//   issue_func   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   issue_opa    rs1 value
//   issue_opb    rs2 value
//   issue_tag    destination tag
//   cdb_valid    result available at buffer head
//   cdb_ready    CDB takes the result
//   cdb_tag      result tag
//   cdb_value    result value

`ifndef MULT_STAGES
`define MULT_STAGES 4
`endif

// Pipelined 64x64 -> 64 multiplier: the product of the operands sampled with
// start appears on product exactly STAGES cycles later. It cannot stall.
// Ports: clock, rst (async, active-high), start, mcand, mplier, product, done.
module mult_pipe #(
    parameter int STAGES = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] mcand,
    input  logic [63:0] mplier,
    output logic [63:0] product,
    output logic        done
);
    logic [63:0]       prod_r [STAGES];
    logic [STAGES-1:0] busy_r;

    // Product and start-marker shift registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                prod_r[i] <= 64'd0;
            end
            busy_r <= {STAGES{1'b0}};
        end else begin
            prod_r[0] <= mcand * mplier;
            busy_r[0] <= start;
            for (int i = 1; i < STAGES; i++) begin
                prod_r[i] <= prod_r[i-1];
                busy_r[i] <= busy_r[i-1];
            end
        end
    end

    assign product = prod_r[STAGES-1];
    assign done    = busy_r[STAGES-1];
endmodule

// Checker for mult_fu invariants that the credit scheme guarantees.
// Ports: clock, reset (active-low), wr, full, pop, empty, last_valid, mult_done.
module mult_fu_chk (
    input logic clock,
    input logic reset,
    input logic wr,
    input logic full,
    input logic pop,
    input logic empty,
    input logic last_valid,
    input logic mult_done
);
    a_no_write_when_full : assert property (@(posedge clock) disable iff (!reset) wr |-> !full);
    a_no_pop_when_empty  : assert property (@(posedge clock) disable iff (!reset) pop |-> !empty);
    a_side_matches_mult  : assert property (@(posedge clock) disable iff (!reset) last_valid |-> mult_done);
endmodule

module mult_fu #(
    parameter int MULT_STAGES = `MULT_STAGES,
    parameter int TAG_W       = 6,
    parameter int OUT_DEPTH   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [1:0]       issue_func,
    input  logic [31:0]      issue_opa,
    input  logic [31:0]      issue_opb,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             cdb_valid,
    input  logic             cdb_ready,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_value
);
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int LAST  = MULT_STAGES - 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(OUT_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1'b1);

    // opa is zero-extended only for MULHU.
    function automatic logic opa_signed(input logic [1:0] func);
        return (func != 2'b11);
    endfunction

    // opb is sign-extended only for MUL and MULH.
    function automatic logic opb_signed(input logic [1:0] func);
        return (func[1] == 1'b0);
    endfunction

    // Circular pointer advance, wrapping at OUT_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUT_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    logic             run_r;
    logic [OCC_W-1:0] occ_r;
    logic             accept_s;
    logic             pop_s;
    logic [63:0]      opa_ext_s;
    logic [63:0]      opb_ext_s;
    logic [63:0]      product_s;
    logic             mult_done_s;
    logic             mult_rst_s;

    logic             sp_valid_r [MULT_STAGES];
    logic [TAG_W-1:0] sp_tag_r   [MULT_STAGES];
    logic [1:0]       sp_func_r  [MULT_STAGES];
    logic             last_valid_s;
    logic             wr_s;
    logic [31:0]      result_s;

    logic [TAG_W-1:0] fifo_tag_r [OUT_DEPTH];
    logic [31:0]      fifo_val_r [OUT_DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [OCC_W-1:0] cnt_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    // run_r keeps issue_ready low while reset is held and through the release cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    assign issue_ready = run_r & ~flush & (occ_r < DEPTH_C);
    assign accept_s    = issue_valid & issue_ready;
    assign pop_s       = cdb_valid & cdb_ready;

    // Credit counter: ops accepted and not yet popped, wherever they are.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ_r <= OCC_ZERO;
        end else if (flush) begin
            occ_r <= OCC_ZERO;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Operand extension selected by the multiply flavour.
    always_comb begin
        opa_ext_s = {32'd0, issue_opa};
        opb_ext_s = {32'd0, issue_opb};
        if (opa_signed(issue_func)) begin
            opa_ext_s = {{32{issue_opa[31]}}, issue_opa};
        end else begin
            opa_ext_s = {32'd0, issue_opa};
        end
        if (opb_signed(issue_func)) begin
            opb_ext_s = {{32{issue_opb[31]}}, issue_opb};
        end else begin
            opb_ext_s = {32'd0, issue_opb};
        end
    end

    assign mult_rst_s = ~reset;

    mult_pipe #(
        .STAGES (MULT_STAGES)
    ) u_mult (
        .clock   (clock),
        .rst     (mult_rst_s),
        .start   (accept_s),
        .mcand   (opa_ext_s),
        .mplier  (opb_ext_s),
        .product (product_s),
        .done    (mult_done_s)
    );

    // Side pipeline carrying {valid, tag, func} in lockstep with the multiplier.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                sp_valid_r[i] <= 1'b0;
                sp_tag_r[i]   <= {TAG_W{1'b0}};
                sp_func_r[i]  <= 2'b00;
            end
        end else begin
            // accept_s is already low under flush, so stage 0 clears too.
            sp_valid_r[0] <= accept_s;
            sp_tag_r[0]   <= issue_tag;
            sp_func_r[0]  <= issue_func;
            for (int i = 1; i < MULT_STAGES; i++) begin
                sp_valid_r[i] <= sp_valid_r[i-1] & ~flush;
                sp_tag_r[i]   <= sp_tag_r[i-1];
                sp_func_r[i]  <= sp_func_r[i-1];
            end
        end
    end

    assign last_valid_s = sp_valid_r[LAST];
    assign wr_s         = last_valid_s & ~flush;

    // MUL returns the low word, every other flavour the high word.
    always_comb begin
        result_s = product_s[63:32];
        if (sp_func_r[LAST] == 2'b00) begin
            result_s = product_s[31:0];
        end else begin
            result_s = product_s[63:32];
        end
    end

    // Output FIFO storage and pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_tag_r[i] <= {TAG_W{1'b0}};
                fifo_val_r[i] <= 32'd0;
            end
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            cnt_r  <= OCC_ZERO;
        end else if (flush) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            cnt_r  <= OCC_ZERO;
        end else begin
            if (wr_s) begin
                fifo_tag_r[tail_r] <= sp_tag_r[LAST];
                fifo_val_r[tail_r] <= result_s;
                tail_r             <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({wr_s, pop_s})
                2'b10:   cnt_r <= cnt_r + OCC_ONE;
                2'b01:   cnt_r <= cnt_r - OCC_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign fifo_empty_s = (cnt_r == OCC_ZERO);
    assign fifo_full_s  = (cnt_r == DEPTH_C);

    // Head entry is presented only when valid so idle/reset outputs read zero.
    assign cdb_valid = ~fifo_empty_s;
    assign cdb_tag   = cdb_valid ? fifo_tag_r[head_r] : {TAG_W{1'b0}};
    assign cdb_value = cdb_valid ? fifo_val_r[head_r] : 32'd0;

    mult_fu_chk u_chk (
        .clock      (clock),
        .reset      (reset),
        .wr         (wr_s),
        .full       (fifo_full_s),
        .pop        (pop_s),
        .empty      (fifo_empty_s),
        .last_valid (last_valid_s),
        .mult_done  (mult_done_s)
    );
endmodule

// File: doc/mult_fu.md
# mult_fu

Multiply functional unit wrapping the team's pipelined 64-bit multiplier: accepts RV32 M-extension multiply ops (MUL, MULH, MULHSU, MULHU) issued from the reservation station and sign- or zero-extends operands to 64 bits for the multiplier. Carries destination tags alongside the multiplier pipeline, selects the low or high 32 bits of the product, and buffers results toward the CDB under a valid/ready handshake. Acceptance is credit-based, so the non-stallable multiplier pipeline never produces a result with nowhere to go.

## Interface
- MULT_STAGES, default `MULT_STAGES (4): multiplier pipeline depth; must match the multiplier instance.
- TAG_W, default 6: destination tag width.
- OUT_DEPTH, default 8: credit limit; output buffer entries. ≥1; ≥ MULT_STAGES+1 for full throughput.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- flush  in  1  squash everything in flight and buffered.
- issue_valid  in  1  op presented.
- issue_ready  out  1  op will be accepted this cycle.
- issue_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- issue_opa, issue_opb  in  32 each  rs1, rs2 values.
- issue_tag  in  TAG_W  destination tag.
- cdb_valid  out  1  result at buffer head.
- cdb_ready  in  1  CDB takes result.
- cdb_tag  out  TAG_W  result tag.
- cdb_value  out  32  result value.

## Operation
- Accept = issue_valid & issue_ready & !flush. issue_ready = !flush & (occupancy < OUT_DEPTH).
- Occupancy counter, width clog2(OUT_DEPTH+1): counts ops accepted but not yet popped, whether in flight or buffered. It increments on accept and decrements on pop (cdb_valid & cdb_ready). Accept and pop in the same cycle leave it unchanged.
- Operand extension:
  - opa is sign-extended for MUL, MULH and MULHSU; zero-extended for MULHU.
  - opb is sign-extended for MUL and MULH; zero-extended for MULHSU and MULHU.
- Multiplier start = accept; mcand = extended opa; mplier = extended opb, driven combinationally from the issue port.
- Multiplier reset = ~reset. The multiplier's own done output is unused.
- Side pipeline: a MULT_STAGES-deep shift register of {valid, tag, func}, advancing every cycle and loaded with {accept, issue_tag, issue_func}.
- Result select: MUL takes product[31:0]; all others take product[63:32]. The result is captured from the multiplier product on the cycle the side pipeline's last-stage valid is 1.
- Output buffer: circular FIFO of OUT_DEPTH entries {tag, value}.
  - Head and tail pointers wrap modulo OUT_DEPTH.
  - Write occurs on last-stage valid; pop on cdb_valid & cdb_ready. Simultaneous write and pop are both honoured.
  - Overflow is impossible by the credit rule. Write-when-full and pop-when-empty are assertion errors.
- cdb_valid = FIFO non-empty. cdb_tag and cdb_value come from the FIFO head, and are held stable while cdb_valid & !cdb_ready.
- Results leave strictly in issue order.
- Flush:
  - Synchronously clears all side-pipeline valids, the FIFO (pointers and count) and the occupancy counter.
  - Flush dominates any same-cycle accept or write.
  - A pop in the flush cycle is still a legal CDB transfer.
- Reset (asynchronous, on reset = 0): all valids, pointers and counters clear immediately. While reset is low: cdb_valid = 0, issue_ready = 0, cdb_tag = 0, cdb_value = 0.

## Timing
- Op accepted in cycle k: last-stage valid is high in cycle k+MULT_STAGES, and cdb_valid is high in cycle k+MULT_STAGES+1 when the FIFO was empty. Latency is MULT_STAGES+1 (5 at default).
- Throughput: one op per cycle with cdb_ready held 1 and OUT_DEPTH ≥ MULT_STAGES+1.
- After a pop, the freed credit is visible on issue_ready in the next cycle.
- Outputs after reset deassertion: cdb_valid = 0 and issue_ready = 1 (unless flush).
- Flush in cycle f: cycle f+1 has cdb_valid = 0 and issue_ready = 1. No pre-flush op ever reaches the CDB.
- Reset asserted mid-operation: outputs clear without a clock edge, and in-flight ops never emerge.

## Test plan
- Reset: hold reset = 0 → cdb_valid = 0, issue_ready = 0. Release → issue_ready = 1 next cycle, cdb_valid stays 0 until an op is accepted.
- Function select: opa = 0xFFFFFFFF, opb = 0x00000002, tag 5, issued in cycle k → cdb_valid in cycle k+5 with tag 5. Required values per func: MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHSU → 0xFFFFFFFF; MULHU → 0x00000001.
- Back-pressure: cdb_ready = 0, issue 8 ops (tags 0–7) → issue_ready = 0 after the 8th accept. Then cdb_ready = 1 → tags 0–7 pop on 8 consecutive cycles, with correct values.
- Throughput: cdb_ready = 1, 20 back-to-back random ops → issue_ready never drops, and 20 in-order results appear on consecutive cycles matching a reference model.
- Flush: 3 ops in flight and 2 buffered, assert flush for one cycle → cdb_valid = 0 and issue_ready = 1 next cycle, and no result appears in the following 10 cycles. An op issued after the flush returns its correct tag and value.
- Async reset mid-stream: drive reset = 0 between clock edges with 4 ops outstanding → cdb_valid falls immediately. After release, no stale results ever appear.
